// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, framing check and a first-word-fall-through
// byte FIFO drained by a valid/ready consumer; sticky framing and overflow flags.
module uart_rx_fifo #(
   parameter int DELAY_FRAMES = 234,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          err_clr
);

   localparam int HALF = DELAY_FRAMES / 2;
   localparam int CW   = $clog2(DELAY_FRAMES);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] LAST    = CW'(DELAY_FRAMES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          push, ferr_evt;
   logic          sync_p0, sync_p1, rx_s;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop, full, wr_en, drop;

   // stage p0/p1: two-flop synchroniser on the asynchronous pin
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= uart_rx;
         sync_p1 <= sync_p0;
      end
   end
   assign rx_s = sync_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
      end
   end

   always_ff @(posedge clk) begin
      shift <= shift_n;
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      bit_n    = bit_idx;
      shift_n  = shift;
      push     = 1'b0;
      ferr_evt = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            // A start bit that has gone high again by mid-bit is treated as a glitch.
            if (cnt == HALF_M1) begin
               if (rx_s) begin
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
                  cnt_n   = '0;
                  bit_n   = '0;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               shift_n = {rx_s, shift[7:1]};
               cnt_n   = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_evt = 1'b1;
                  state_n  = BREAK;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BREAK: begin
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // A full FIFO still accepts a byte when the head is popped in the same cycle.
   assign rx_valid = (fifo_count != '0);
   assign pop      = rx_valid && rx_ready;
   assign full     = (fifo_count == FULL_CNT);
   assign wr_en    = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Error events take priority over a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (ferr_evt)     frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (drop)         overflow  <= 1'b1;
         else if (err_clr) overflow  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are generated bit by bit, expected bytes are
// queued at issue time and a negedge monitor checks every handshake in order.
module tb_uart_rx_fifo;

   localparam int DF    = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] fifo_count;
   logic       frame_err;
   logic       overflow;
   logic       err_clr = 1'b0;

   logic       rdy_cfg = 1'b0;
   logic       rnd_mode = 1'b0;
   logic       rnd_bit = 1'b0;
   assign rx_ready = rnd_mode ? rnd_bit : rdy_cfg;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       exp_ferr = 1'b0;
   logic       exp_ovf  = 1'b0;

   uart_rx_fifo #(.DELAY_FRAMES(DF), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .uart_rx(line), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .fifo_count(fifo_count), .frame_err(frame_err),
      .overflow(overflow), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1 rnd_bit = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every handshake must deliver the oldest outstanding expected byte,
   // and a stalled head must hold still.
   logic       hold_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("stall_valid", {31'd0, rx_valid}, 32'd1);
            chk("stall_data", {24'd0, rx_data}, {24'd0, data_prev});
         end
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got %0h expected nothing", rx_data);
            end else begin
               chk("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
         end
         hold_prev = rx_valid && !rx_ready;
         data_prev = rx_data;
      end
   end

   // Called at posedge+1; drives start, 8 data bits LSB first, stop.
   task automatic send_frame(input logic [7:0] b, input bit bad);
      if (!bad) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else                      exp_ovf = 1'b1;
      end else begin
         exp_ferr = 1'b1;
      end
      for (int i = 0; i < 10; i++) begin
         line = (i == 0) ? 1'b0 : (i == 9) ? !bad : b[i-1];
         repeat (DF) @(posedge clk);
         #1;
      end
      if (bad) begin
         repeat (DF) @(posedge clk);
         #1 line = 1'b1;
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"}, {29'd0, fifo_count}, exp_q.size());
      chk({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, exp_ferr});
      chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_data", {24'd0, rx_data}, 32'd0);
      chk_state("rst");
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // T1
      send_frame(8'hA5, 1'b0);
      chk("t1_valid", {31'd0, rx_valid}, 32'd1);
      chk("t1_data", {24'd0, rx_data}, 32'hA5);
      chk_state("t1");
      rdy_cfg = 1'b1;
      wait_empty("t1_drain");
      rdy_cfg = 1'b0;

      // T2
      rdy_cfg = 1'b1;
      send_frame(8'h48, 1'b0);
      send_frame(8'h65, 1'b0);
      send_frame(8'h6C, 1'b0);
      wait_empty("t2_drain");
      chk_state("t2");
      rdy_cfg = 1'b0;

      // T3
      line = 1'b0;
      repeat (5) @(posedge clk);
      #1 line = 1'b1;
      repeat (3 * DF) @(posedge clk);
      #1;
      chk("t3_valid", {31'd0, rx_valid}, 32'd0);
      chk_state("t3");

      // T4
      send_frame(8'h55, 1'b1);
      chk_state("t4_bad");
      send_frame(8'h3C, 1'b0);
      chk("t4_data", {24'd0, rx_data}, 32'h3C);
      chk_state("t4_good");
      pulse_clr();
      chk_state("t4_clr");
      rdy_cfg = 1'b1;
      wait_empty("t4_drain");
      rdy_cfg = 1'b0;

      // T5
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
      chk("t5_head", {24'd0, rx_data}, 32'h01);
      chk_state("t5");
      rdy_cfg = 1'b1;
      wait_empty("t5_drain");
      rdy_cfg = 1'b0;
      pulse_clr();
      chk_state("t5_clr");

      // T6
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b0);
      chk_state("t6_pre");
      line = 1'b0;
      repeat (DF) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         #1 line = i[0];
         repeat (DF) @(posedge clk);
      end
      #1;
      rst = 1'b1;
      line = 1'b1;
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("t6_valid", {31'd0, rx_valid}, 32'd0);
      chk_state("t6_rst");
      repeat (4) @(posedge clk);
      #1;
      send_frame(8'h7E, 1'b0);
      chk("t6_data", {24'd0, rx_data}, 32'h7E);
      chk_state("t6_post");
      rdy_cfg = 1'b1;
      wait_empty("t6_drain");
      rdy_cfg = 1'b0;

      // Randomized traffic with a random consumer and occasional framing errors
      rnd_mode = 1'b1;
      for (int n = 0; n < 20; n++) begin
         bit bad;
         bad = ($urandom_range(0, 5) == 0);
         send_frame(8'($urandom), bad);
         chk("rnd_ferr", {31'd0, frame_err}, {31'd0, exp_ferr});
         if (bad) begin
            pulse_clr();
            chk("rnd_ferr_clr", {31'd0, frame_err}, 32'd0);
         end
         repeat ($urandom_range(0, 20)) @(posedge clk);
         #1;
      end
      wait_empty("rnd_drain");
      rnd_mode = 1'b0;
      @(posedge clk);
      #1;
      chk_state("rnd_end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
